// File: rtl/axis_argmax_pkg.sv
// Shared types and width helpers for the AXI-stream argmax block.
// AXIS_ARGMAX_VALUE_OUT_EN adds the winning value to the result beat.
package axis_argmax_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Index width for a frame of n beats, never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_argmax_if.sv
// Upstream beat stream and downstream result stream of axis_argmax.
// AXIS_ARGMAX_VALUE_OUT_EN widens m_axis_data to {value, index}.
interface axis_argmax_if
  import axis_argmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 35,
  parameter int unsigned FRAME_LEN  = 2
);
  localparam int unsigned IDX_WIDTH = idx_width(FRAME_LEN);
`ifdef AXIS_ARGMAX_VALUE_OUT_EN
  localparam int unsigned OUT_WIDTH = DATA_WIDTH + IDX_WIDTH;
`else
  localparam int unsigned OUT_WIDTH = IDX_WIDTH;
`endif

  logic                  s_axis_valid;
  logic [DATA_WIDTH-1:0] s_axis_data;
  logic                  s_axis_ready;
  logic                  m_axis_valid;
  logic [OUT_WIDTH-1:0]  m_axis_data;
  logic                  m_axis_ready;

  // The argmax block
  modport slave (
    input  s_axis_valid, s_axis_data, m_axis_ready,
    output s_axis_ready, m_axis_valid, m_axis_data
  );

  // The surrounding producer/consumer
  modport master (
    output s_axis_valid, s_axis_data, m_axis_ready,
    input  s_axis_ready, m_axis_valid, m_axis_data
  );

endinterface

// File: rtl/argmax_cmp.sv
// Signed compare-select: keeps the incumbent unless the new beat is strictly
// larger, or the new beat opens a frame.
module argmax_cmp #(
  parameter int unsigned DATA_WIDTH = 35,
  parameter int unsigned IDX_WIDTH  = 1
) (
  input  logic signed [DATA_WIDTH-1:0] cur_val,
  input  logic        [IDX_WIDTH-1:0]  cur_idx,
  input  logic signed [DATA_WIDTH-1:0] in_val,
  input  logic        [IDX_WIDTH-1:0]  in_idx,
  input  logic                         first,
  output logic signed [DATA_WIDTH-1:0] sel_val_c,
  output logic        [IDX_WIDTH-1:0]  sel_idx_c
);

  // Strict '>' so ties keep the earlier index
  always_comb begin
    sel_val_c = cur_val;
    sel_idx_c = cur_idx;
    if (first || (in_val > cur_val)) begin
      sel_val_c = in_val;
      sel_idx_c = in_idx;
    end
  end

endmodule

// File: rtl/axis_argmax.sv
// Frame-wise argmax over FRAME_LEN signed beats; one registered result per frame.
// AXIS_ARGMAX_VALUE_OUT_EN also returns the winning value as {value, index}.
module axis_argmax
  import axis_argmax_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 2,
  parameter int unsigned DATA_WIDTH = 35
) (
  input  logic          axi_clk,
  input  logic          axi_reset_n,
  axis_argmax_if.slave  bus
);

  localparam int unsigned           IDX_WIDTH = idx_width(FRAME_LEN);
  localparam logic [IDX_WIDTH-1:0]  LAST_BEAT = IDX_WIDTH'(FRAME_LEN - 1);

  state_e                        state;
  logic        [IDX_WIDTH-1:0]   cnt;
  logic signed [DATA_WIDTH-1:0]  best_val;
  logic        [IDX_WIDTH-1:0]   best_idx;
  logic        [IDX_WIDTH-1:0]   res_idx;
  logic                          s_ready_q;
  logic                          m_valid_q;

  logic signed [DATA_WIDTH-1:0]  sel_val_c;
  logic        [IDX_WIDTH-1:0]   sel_idx_c;
  logic                          accept_c;
  logic                          last_c;

  assign accept_c = bus.s_axis_valid && s_ready_q;
  assign last_c   = accept_c && (cnt == LAST_BEAT);

  argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_cmp (
    .cur_val   (best_val),
    .cur_idx   (best_idx),
    .in_val    (bus.s_axis_data),
    .in_idx    (cnt),
    .first     (cnt == '0),
    .sel_val_c (sel_val_c),
    .sel_idx_c (sel_idx_c)
  );

  // Accumulate a frame, then hold the result until the consumer takes it
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      res_idx   <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (last_c) begin
            res_idx   <= sel_idx_c;
            cnt       <= '0;
            state     <= HOLD;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b1;
          end else if (accept_c) begin
            best_val  <= sel_val_c;
            best_idx  <= sel_idx_c;
            cnt       <= cnt + IDX_WIDTH'(1);
          end
        end
        HOLD: begin
          if (bus.m_axis_ready) begin
            state     <= ACCUM;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef AXIS_ARGMAX_VALUE_OUT_EN
  logic signed [DATA_WIDTH-1:0] res_val;

  // Winning value captured alongside the index on the closing beat
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      res_val <= '0;
    end else if ((state == ACCUM) && last_c) begin
      res_val <= sel_val_c;
    end
  end

  assign bus.m_axis_data = {res_val, res_idx};
`else
  assign bus.m_axis_data = res_idx;
`endif

  assign bus.s_axis_ready = s_ready_q;
  assign bus.m_axis_valid = m_valid_q;

endmodule
